// File: rtl/adder_err_stats.sv
// adder_err_stats: error-statistics accumulator for an approximate adder under test.
// Each accepted sample (in_a, in_b, in_sum) is checked against the exact N-bit sum.
// The block accumulates the sample count, the mismatch count, the saturating sum of
// error distances and the maximum error distance over a programmed number of samples.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             one-cycle pulse, starts a run from IDLE or DONE
//   num_samples       samples to accept in the run, latched on start
//   in_valid/in_ready sample handshake; a sample is taken when both are high
//   in_a, in_b        operands seen by the adder under test
//   in_sum            approximate sum produced by the adder under test
//   busy              run in progress (RUN or DRAIN)
//   done              run finished; totals are final until the next start
//   sample_count      samples accumulated so far
//   err_count         samples whose in_sum differed from the exact sum
//   sed_total         saturating sum of error distances
//   max_ed            largest error distance seen
module adder_err_stats #(
   parameter int unsigned N     = 16,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned ACC_W = 48
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic [N-1:0]     in_sum,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_count,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sed_total,
   output logic [N-1:0]     max_ed
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e           state_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] num_q;
   logic [CNT_W-1:0] accepted_q;

   // Stage 1 holds the accepted sample; stage 2 holds its error distance.
   logic             s1_valid_q;
   logic [N-1:0]     s1_a_q;
   logic [N-1:0]     s1_b_q;
   logic [N-1:0]     s1_sum_q;
   logic             s2_valid_q;
   logic             s2_mis_q;
   logic [N-1:0]     s2_ed_q;

   logic [CNT_W-1:0] sample_count_q;
   logic [CNT_W-1:0] err_count_q;
   logic [ACC_W-1:0] sed_total_q;
   logic [N-1:0]     max_ed_q;

   logic             accept;
   logic             last_accept;
   logic             start_ok;
   logic [N-1:0]     exact;
   logic [N-1:0]     ed;
   logic [ACC_W:0]   sed_sum;
   logic [ACC_W-1:0] sed_next;

   assign in_ready    = (state_q == StRun) && (accepted_q < num_q);
   assign accept      = in_valid && in_ready;
   assign last_accept = accept && ((accepted_q + CNT_W'(1)) == num_q);
   assign start_ok    = start && ((state_q == StIdle) || (state_q == StDone));

   assign busy         = busy_q;
   assign done         = done_q;
   assign sample_count = sample_count_q;
   assign err_count    = err_count_q;
   assign sed_total    = sed_total_q;
   assign max_ed       = max_ed_q;

   // Carry-out of the exact sum is discarded; the distance always fits in N bits.
   always_comb begin
      exact = s1_a_q + s1_b_q;
      ed    = '0;
      if (s1_sum_q >= exact) begin
         ed = s1_sum_q - exact;
      end else begin
         ed = exact - s1_sum_q;
      end
   end

   // One extra bit catches the accumulator overflow so it can clamp to all-ones.
   always_comb begin
      sed_sum  = {1'b0, sed_total_q} + (ACC_W+1)'(s2_ed_q);
      sed_next = sed_sum[ACC_W] ? '1 : sed_sum[ACC_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         num_q      <= '0;
         accepted_q <= '0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q    <= StRun;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  num_q      <= num_samples;
                  accepted_q <= '0;
               end
            end
            StRun: begin
               if (accept) begin
                  accepted_q <= accepted_q + CNT_W'(1);
               end
               // Leave on the final accept, or at once when the run asked for zero samples.
               if (last_accept || (accepted_q == num_q)) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               // Stage 1 empty means stage 2 retires this edge, so totals are final together
               // with done.
               if (!s1_valid_q) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_sum_q   <= '0;
         s2_valid_q <= 1'b0;
         s2_mis_q   <= 1'b0;
         s2_ed_q    <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_a_q   <= in_a;
            s1_b_q   <= in_b;
            s1_sum_q <= in_sum;
         end
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_ed_q  <= ed;
            s2_mis_q <= (ed != '0);
         end
      end
   end

   // A start is only honoured with the pipeline empty, so clear and update never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sample_count_q <= '0;
         err_count_q    <= '0;
         sed_total_q    <= '0;
         max_ed_q       <= '0;
      end else if (start_ok) begin
         sample_count_q <= '0;
         err_count_q    <= '0;
         sed_total_q    <= '0;
         max_ed_q       <= '0;
      end else if (s2_valid_q) begin
         sample_count_q <= sample_count_q + CNT_W'(1);
         err_count_q    <= err_count_q + CNT_W'(s2_mis_q);
         sed_total_q    <= sed_next;
         if (s2_ed_q > max_ed_q) begin
            max_ed_q <= s2_ed_q;
         end
      end
   end

endmodule

// File: tb/tb_adder_err_stats.sv
// Testbench for adder_err_stats: table of single-sample runs plus hand-written
// multi-cycle sequences. A second instance with a narrow accumulator shares the
// stimulus and exercises saturation.
module tb_adder_err_stats;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] num_samples;
   logic        in_valid;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic [15:0] in_sum;

   logic        in_ready;
   logic        busy;
   logic        done;
   logic [31:0] sample_count;
   logic [31:0] err_count;
   logic [47:0] sed_total;
   logic [15:0] max_ed;

   logic        sat_in_ready;
   logic        sat_busy;
   logic        sat_done;
   logic [31:0] sat_sample_count;
   logic [31:0] sat_err_count;
   logic [16:0] sat_sed_total;
   logic [15:0] sat_max_ed;

   int tests = 0;
   int fails = 0;

   adder_err_stats #(.N(16), .CNT_W(32), .ACC_W(48)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_sum(in_sum), .busy(busy), .done(done), .sample_count(sample_count),
      .err_count(err_count), .sed_total(sed_total), .max_ed(max_ed)
   );

   adder_err_stats #(.N(16), .CNT_W(32), .ACC_W(17)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(sat_in_ready), .in_a(in_a), .in_b(in_b),
      .in_sum(in_sum), .busy(sat_busy), .done(sat_done),
      .sample_count(sat_sample_count), .err_count(sat_err_count),
      .sed_total(sat_sed_total), .max_ed(sat_max_ed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] sum;
      logic [15:0] ed;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic start_run(input logic [31:0] n);
      @(negedge clk);
      start       = 1'b1;
      num_samples = n;
      @(negedge clk);
      start       = 1'b0;
   endtask

   // Returns at the negedge following the accepting edge.
   task automatic feed_one(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
      int k;
      in_a     = a;
      in_b     = b;
      in_sum   = s;
      in_valid = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("ready_wait", 64'(k < 50), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("done_wait", 64'(k < 20), 64'(1));
   endtask

   initial begin
      logic seen_ready;

      vecs[0] = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};
      vecs[1] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
      vecs[2] = '{16'h1234, 16'h4321, 16'h5555, 16'h0000};
      vecs[3] = '{16'h1000, 16'h1000, 16'h1FFF, 16'h0001};
      vecs[4] = '{16'h8000, 16'h0000, 16'h7F00, 16'h0100};
      vecs[5] = '{16'h0010, 16'h0010, 16'h0030, 16'h0010};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0000};
      vecs[7] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
      vecs[8] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'hFFFF};

      rst_n       = 1'b0;
      start       = 1'b0;
      num_samples = '0;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      in_sum      = '0;

      // Reset state
      #12;
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_sample_count", 64'(sample_count), 64'(0));
      check("rst_err_count", 64'(err_count), 64'(0));
      check("rst_sed_total", 64'(sed_total), 64'(0));
      check("rst_max_ed", 64'(max_ed), 64'(0));
      check("rst_sat_in_ready", 64'(sat_in_ready), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Single-sample runs from the table
      for (int i = 0; i < 9; i++) begin
         start_run(32'd1);
         feed_one(vecs[i].a, vecs[i].b, vecs[i].sum);
         wait_done();
         check($sformatf("vec%0d_sample_count", i), 64'(sample_count), 64'(1));
         check($sformatf("vec%0d_err_count", i), 64'(err_count), 64'(vecs[i].ed != 16'h0));
         check($sformatf("vec%0d_sed_total", i), 64'(sed_total), 64'(vecs[i].ed));
         check($sformatf("vec%0d_max_ed", i), 64'(max_ed), 64'(vecs[i].ed));
         check($sformatf("vec%0d_busy", i), 64'(busy), 64'(0));
      end

      // Three exact samples including a wrapping one
      start_run(32'd3);
      for (int i = 0; i < 3; i++) feed_one(vecs[i].a, vecs[i].b, vecs[i].sum);
      wait_done();
      check("exact_sample_count", 64'(sample_count), 64'(3));
      check("exact_err_count", 64'(err_count), 64'(0));
      check("exact_sed_total", 64'(sed_total), 64'(0));
      check("exact_max_ed", 64'(max_ed), 64'(0));
      check("exact_done", 64'(done), 64'(1));

      // Three erroneous samples
      start_run(32'd3);
      for (int i = 3; i < 6; i++) feed_one(vecs[i].a, vecs[i].b, vecs[i].sum);
      wait_done();
      check("err_sample_count", 64'(sample_count), 64'(3));
      check("err_err_count", 64'(err_count), 64'(3));
      check("err_sed_total", 64'(sed_total), 64'(16'h0111));
      check("err_max_ed", 64'(max_ed), 64'(16'h0100));

      // Latency: accept at edge t, visible only after edge t+2
      start_run(32'd1);
      in_a = 16'h1000; in_b = 16'h1000; in_sum = 16'h1FFF; in_valid = 1'b1;
      check("lat_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      check("lat_count_t0", 64'(sample_count), 64'(0));
      @(negedge clk);
      check("lat_count_t1", 64'(sample_count), 64'(0));
      @(negedge clk);
      check("lat_count_t2", 64'(sample_count), 64'(1));
      check("lat_done_t2", 64'(done), 64'(1));

      // Backpressure with in_valid held high, num_samples=2
      start_run(32'd2);
      in_a = 16'h0000; in_b = 16'h0001; in_sum = 16'h0003; in_valid = 1'b1;
      check("bp_ready0", 64'(in_ready), 64'(1));
      @(negedge clk);
      check("bp_ready1", 64'(in_ready), 64'(1));
      @(negedge clk);
      check("bp_ready_after", 64'(in_ready), 64'(0));
      @(negedge clk);
      check("bp_ready_hold", 64'(in_ready), 64'(0));
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_done", 64'(done), 64'(1));
      check("bp_sample_count", 64'(sample_count), 64'(2));
      check("bp_sed_total", 64'(sed_total), 64'(4));

      // num_samples=0: no accepts, straight to DONE with cleared stats
      start_run(32'd0);
      in_valid   = 1'b1;
      seen_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (in_ready) seen_ready = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      check("zero_ready_seen", 64'(seen_ready), 64'(0));
      check("zero_done", 64'(done), 64'(1));
      check("zero_sample_count", 64'(sample_count), 64'(0));
      check("zero_err_count", 64'(err_count), 64'(0));
      check("zero_sed_total", 64'(sed_total), 64'(0));
      check("zero_max_ed", 64'(max_ed), 64'(0));

      // Saturation on the 17-bit accumulator
      start_run(32'd4);
      for (int i = 0; i < 3; i++) feed_one(16'h0000, 16'h0000, 16'hFFFF);
      @(negedge clk);
      @(negedge clk);
      check("sat_sed_3", 64'(sat_sed_total), 64'(17'h1FFFF));
      check("sat_err_3", 64'(sat_err_count), 64'(3));
      feed_one(16'h0000, 16'h0000, 16'hFFFF);
      wait_done();
      check("sat_sed_4", 64'(sat_sed_total), 64'(17'h1FFFF));
      check("sat_err_4", 64'(sat_err_count), 64'(4));
      check("sat_sample_count", 64'(sat_sample_count), 64'(4));
      check("sat_max_ed", 64'(sat_max_ed), 64'(16'hFFFF));
      check("sat_done", 64'(sat_done), 64'(1));
      check("sat_busy", 64'(sat_busy), 64'(0));
      check("wide_sed_4", 64'(sed_total), 64'(48'h3FFFC));

      // Reset mid-run after 5 of 10 samples, with samples still in flight
      start_run(32'd10);
      for (int i = 0; i < 5; i++) feed_one(16'h0001, 16'h0001, 16'h0005);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      check("mid_rst_in_ready", 64'(in_ready), 64'(0));
      check("mid_rst_sample_count", 64'(sample_count), 64'(0));
      check("mid_rst_err_count", 64'(err_count), 64'(0));
      check("mid_rst_sed_total", 64'(sed_total), 64'(0));
      check("mid_rst_max_ed", 64'(max_ed), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("post_rst_sample_count", 64'(sample_count), 64'(0));
      check("post_rst_busy", 64'(busy), 64'(0));

      // Restart with num_samples=1; a start while busy must be ignored
      start_run(32'd1);
      check("restart_busy", 64'(busy), 64'(1));
      start_run(32'd5);
      check("ignored_start_busy", 64'(busy), 64'(1));
      feed_one(16'h0002, 16'h0003, 16'h0005);
      wait_done();
      check("restart_done", 64'(done), 64'(1));
      check("restart_sample_count", 64'(sample_count), 64'(1));
      check("restart_err_count", 64'(err_count), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
